l1_cache_ctrl: RTL

- Direct-mapped, write-through, no-write-allocate controller sequencing the 8-entry x 8-bit L1 data array.
- Owns the tag/valid store and the CPU-side request handshake.
- Drives the array's read_select/write_select/write_data/write_enable and consumes its registered out_data.
- Services misses and all writes through a req/ack handshake to the next memory level.

---
 rtl/l1_cache_pkg.sv | 16 +
 rtl/l1_tag_store.sv | 33 +++
 rtl/l1_cache_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types and sizing for the L1 cache controller and its tag store.
package l1_cache_pkg;
    localparam int L1_ADDR_W = 8;
    localparam int L1_DATA_W = 8;
    localparam int INDEX_W   = 3;
    localparam int TAG_W     = L1_ADDR_W - INDEX_W;
    localparam int LINES     = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FILL   = 3'd2,
        WTHRU  = 3'd3,
        RESP   = 3'd4
    } state_e;
endpackage

// File: rtl/l1_tag_store.sv
// Valid + tag registers for the direct-mapped L1: flush-all, one write port, combinational hit.
module l1_tag_store
    import l1_cache_pkg::*;
#(
    parameter int TAG_BITS = TAG_W
) (
    input  logic                cache_clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                wr_en_i,
    input  logic [INDEX_W-1:0]  wr_idx_i,
    input  logic [TAG_BITS-1:0] wr_tag_i,
    input  logic [INDEX_W-1:0]  lk_idx_i,
    input  logic [TAG_BITS-1:0] lk_tag_i,
    output logic                hit_o
);
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];

    always_ff @(posedge cache_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            tag_q[wr_idx_i]   <= wr_tag_i;
        end
    end

    assign hit_o = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 controller driving an 8x8 data array.
// Define L1_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module l1_cache_ctrl
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W = L1_ADDR_W,
    parameter int DATA_W = L1_DATA_W
) (
    input  logic              cache_clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_flush,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [2:0]        read_select,
    output logic [2:0]        write_select,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    input  logic [DATA_W-1:0] out_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef L1_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);
    localparam int TW = ADDR_W - INDEX_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              flush_all;
    logic              tag_wr;
    logic              hit;

    wire [INDEX_W-1:0] idx_q = addr_q[INDEX_W-1:0];
    wire [TW-1:0]      tag_l = addr_q[ADDR_W-1:INDEX_W];

    l1_tag_store #(.TAG_BITS(TW)) u_tags (
        .cache_clk (cache_clk),
        .rst_n     (rst_n),
        .flush_i   (flush_all),
        .wr_en_i   (tag_wr),
        .wr_idx_i  (idx_q),
        .wr_tag_i  (tag_l),
        .lk_idx_i  (idx_q),
        .lk_tag_i  (tag_l),
        .hit_o     (hit)
    );

    always_ff @(posedge cache_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        flush_all    = 1'b0;
        tag_wr       = 1'b0;
        read_select  = idx_q;
        write_select = idx_q;
        write_data   = wdata_q;
        write_enable = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        cpu_done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Present the incoming index now so registered out_data is ready in LOOKUP.
                read_select = cpu_addr[INDEX_W-1:0];
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = LOOKUP;
                end else if (cpu_flush) begin
                    flush_all = 1'b1;
                    state_d   = RESP;
                end
            end
            LOOKUP: begin
                if (!we_q) begin
                    if (hit) begin
                        rdata_d = out_data;
                        state_d = RESP;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    write_enable = hit;
                    state_d      = WTHRU;
                end
            end
            FILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    write_enable = 1'b1;
                    write_data   = mem_rdata;
                    tag_wr       = 1'b1;
                    rdata_d      = mem_rdata;
                    state_d      = RESP;
                end
            end
            WTHRU: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_d = RESP;
            end
            RESP: begin
                cpu_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_busy  = (state_q != IDLE);
    assign cpu_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef L1_CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge cache_clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (flush_all) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit && hit_cnt_q != 16'hFFFF)        hit_cnt_q  <= hit_cnt_q + 16'd1;
            else if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule
